// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands/controls, detects load-use hazards,
// inserts bubbles on hazard or branch flush, and keeps saturating stall/flush counters.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ID_valid,
   input  logic [XLEN-1:0]  ID_pc,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic             ID_use_rs1,
   input  logic             ID_use_rs2,
   input  logic [4:0]       ID_wr,
   input  logic             ID_we,
   input  logic [XLEN-1:0]  ID_rD1,
   input  logic [XLEN-1:0]  ID_rD2,
   input  logic [XLEN-1:0]  ID_imm,
   input  logic [3:0]       ID_alu_op,
   input  logic             ID_mem_rd,
   input  logic             ID_mem_we,
   input  logic [1:0]       ID_wd_sel,
   input  logic             EX_flush,
   input  logic             hold,
   output logic             stall_if_id,
   output logic             EX_valid,
   output logic [XLEN-1:0]  EX_pc,
   output logic [4:0]       EX_rs1,
   output logic [4:0]       EX_rs2,
   output logic [4:0]       EX_wr,
   output logic             EX_we,
   output logic [XLEN-1:0]  EX_rD1,
   output logic [XLEN-1:0]  EX_rD2,
   output logic [XLEN-1:0]  EX_imm,
   output logic [3:0]       EX_alu_op,
   output logic             EX_mem_rd,
   output logic             EX_mem_we,
   output logic [1:0]       EX_wd_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      wr;
      logic            we;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [3:0]      alu_op;
      logic            mem_rd;
      logic            mem_we;
      logic [1:0]      wd_sel;
   } ex_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   ex_t  ex_q;
   ex_t  id_d;
   logic lu;

   // Side-effecting controls are gated by validity so an invalid ID slot behaves as a bubble.
   always_comb begin
      id_d        = '0;
      id_d.valid  = ID_valid;
      id_d.pc     = ID_pc;
      id_d.rs1    = ID_rs1;
      id_d.rs2    = ID_rs2;
      id_d.wr     = ID_wr;
      id_d.we     = ID_we & ID_valid;
      id_d.rd1    = ID_rD1;
      id_d.rd2    = ID_rD2;
      id_d.imm    = ID_imm;
      id_d.alu_op = ID_alu_op;
      id_d.mem_rd = ID_mem_rd & ID_valid;
      id_d.mem_we = ID_mem_we & ID_valid;
      id_d.wd_sel = ID_wd_sel;
   end

   // A load's data only exists after MEM, so a consumer right behind it must wait one bubble.
   always_comb begin
      lu = ex_q.valid & ex_q.mem_rd & ex_q.we & (ex_q.wr != 5'd0) & ID_valid
         & ((ID_use_rs1 & (ID_rs1 == ex_q.wr)) | (ID_use_rs2 & (ID_rs2 == ex_q.wr)));
   end

   assign stall_if_id = (lu | hold) & ~EX_flush & ~rst;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q      <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (EX_flush) begin
         ex_q <= '0;
         if (ID_valid && flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (!hold) begin
         if (lu) begin
            ex_q <= '0;
            if (stall_cnt != CNT_MAX)
               stall_cnt <= stall_cnt + CNT_W'(1);
         end else begin
            ex_q <= id_d;
         end
      end
   end

   assign EX_valid  = ex_q.valid;
   assign EX_pc     = ex_q.pc;
   assign EX_rs1    = ex_q.rs1;
   assign EX_rs2    = ex_q.rs2;
   assign EX_wr     = ex_q.wr;
   assign EX_we     = ex_q.we;
   assign EX_rD1    = ex_q.rd1;
   assign EX_rD2    = ex_q.rd2;
   assign EX_imm    = ex_q.imm;
   assign EX_alu_op = ex_q.alu_op;
   assign EX_mem_rd = ex_q.mem_rd;
   assign EX_mem_we = ex_q.mem_we;
   assign EX_wd_sel = ex_q.wd_sel;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic against a cycle-level reference model.
module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        use1;
      logic        use2;
      logic [4:0]  wr;
      logic        we;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        mrd;
      logic        mwe;
      logic [1:0]  wds;
   } instr_t;

   typedef struct {
      instr_t      id;
      logic        flush;
      logic        hold;
      logic        exp_stall;
      logic        exp_valid;
      logic [4:0]  exp_wr;
      logic [31:0] exp_imm;
      int          exp_scnt;
      int          exp_fcnt;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             ID_valid, ID_use_rs1, ID_use_rs2, ID_we, ID_mem_rd, ID_mem_we;
   logic [XLEN-1:0]  ID_pc, ID_rD1, ID_rD2, ID_imm;
   logic [4:0]       ID_rs1, ID_rs2, ID_wr;
   logic [3:0]       ID_alu_op;
   logic [1:0]       ID_wd_sel;
   logic             EX_flush, hold;
   logic             stall_if_id, EX_valid, EX_we, EX_mem_rd, EX_mem_we;
   logic [XLEN-1:0]  EX_pc, EX_rD1, EX_rD2, EX_imm;
   logic [4:0]       EX_rs1, EX_rs2, EX_wr;
   logic [3:0]       EX_alu_op;
   logic [1:0]       EX_wd_sel;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model state: what EX should hold and how many events have been counted.
   instr_t m_ex;
   int     m_stall;
   int     m_flush;
   instr_t cur;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .ID_valid(ID_valid), .ID_pc(ID_pc), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_wr(ID_wr), .ID_we(ID_we),
      .ID_rD1(ID_rD1), .ID_rD2(ID_rD2), .ID_imm(ID_imm), .ID_alu_op(ID_alu_op),
      .ID_mem_rd(ID_mem_rd), .ID_mem_we(ID_mem_we), .ID_wd_sel(ID_wd_sel),
      .EX_flush(EX_flush), .hold(hold), .stall_if_id(stall_if_id),
      .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_wr(EX_wr),
      .EX_we(EX_we), .EX_rD1(EX_rD1), .EX_rD2(EX_rD2), .EX_imm(EX_imm),
      .EX_alu_op(EX_alu_op), .EX_mem_rd(EX_mem_rd), .EX_mem_we(EX_mem_we),
      .EX_wd_sel(EX_wd_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic instr_t mk(input logic valid, input logic [4:0] wr, input logic we,
                                 input logic mrd, input logic [4:0] rs1, input logic use1,
                                 input logic [4:0] rs2, input logic use2, input logic [31:0] imm);
      instr_t i;
      i       = '0;
      i.valid = valid;
      i.pc    = 32'h0000_1000 + {27'd0, wr};
      i.rs1   = rs1;
      i.rs2   = rs2;
      i.use1  = use1;
      i.use2  = use2;
      i.wr    = wr;
      i.we    = we;
      i.rd1   = 32'hA000_0000 + {27'd0, rs1};
      i.rd2   = 32'hB000_0000 + {27'd0, rs2};
      i.imm   = imm;
      i.alu   = 4'h3;
      i.mrd   = mrd;
      i.wds   = {1'b0, mrd};
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      i       = '0;
      i.valid = ($urandom_range(0, 3) != 0);
      i.pc    = $urandom;
      i.rs1   = 5'($urandom_range(0, 3));
      i.rs2   = 5'($urandom_range(0, 3));
      i.use1  = 1'($urandom);
      i.use2  = 1'($urandom);
      i.wr    = 5'($urandom_range(0, 3));
      i.we    = ($urandom_range(0, 3) != 0);
      i.rd1   = $urandom;
      i.rd2   = $urandom;
      i.imm   = $urandom;
      i.alu   = 4'($urandom);
      i.mrd   = 1'($urandom);
      i.mwe   = 1'($urandom);
      i.wds   = 2'($urandom);
      return i;
   endfunction

   // The ID instruction must wait if it reads the nonzero register an in-flight load writes.
   function automatic logic model_load_use(input instr_t ex, input instr_t id);
      if (!(ex.valid && ex.mrd && ex.we && ex.wr != 0 && id.valid)) return 1'b0;
      return (id.use1 && id.rs1 == ex.wr) || (id.use2 && id.rs2 == ex.wr);
   endfunction

   task automatic compare_outputs();
      check("EX_valid",  {63'd0, EX_valid},  {63'd0, m_ex.valid});
      check("EX_pc",     {32'd0, EX_pc},     {32'd0, m_ex.pc});
      check("EX_rs1",    {59'd0, EX_rs1},    {59'd0, m_ex.rs1});
      check("EX_rs2",    {59'd0, EX_rs2},    {59'd0, m_ex.rs2});
      check("EX_wr",     {59'd0, EX_wr},     {59'd0, m_ex.wr});
      check("EX_we",     {63'd0, EX_we},     {63'd0, m_ex.we});
      check("EX_rD1",    {32'd0, EX_rD1},    {32'd0, m_ex.rd1});
      check("EX_rD2",    {32'd0, EX_rD2},    {32'd0, m_ex.rd2});
      check("EX_imm",    {32'd0, EX_imm},    {32'd0, m_ex.imm});
      check("EX_alu_op", {60'd0, EX_alu_op}, {60'd0, m_ex.alu});
      check("EX_mem_rd", {63'd0, EX_mem_rd}, {63'd0, m_ex.mrd});
      check("EX_mem_we", {63'd0, EX_mem_we}, {63'd0, m_ex.mwe});
      check("EX_wd_sel", {62'd0, EX_wd_sel}, {62'd0, m_ex.wds});
      check("stall_cnt", {59'd0, stall_cnt}, 64'(m_stall));
      check("flush_cnt", {59'd0, flush_cnt}, 64'(m_flush));
   endtask

   // One clock: drive ID + controls, check stall_if_id mid-cycle, advance, check registers.
   task automatic step(input instr_t id, input logic fl, input logic hd, input logic rs);
      logic lu;
      logic exp_stall;
      cur        = id;
      rst        = rs;
      EX_flush   = fl;
      hold       = hd;
      ID_valid   = id.valid;
      ID_pc      = id.pc;
      ID_rs1     = id.rs1;
      ID_rs2     = id.rs2;
      ID_use_rs1 = id.use1;
      ID_use_rs2 = id.use2;
      ID_wr      = id.wr;
      ID_we      = id.we;
      ID_rD1     = id.rd1;
      ID_rD2     = id.rd2;
      ID_imm     = id.imm;
      ID_alu_op  = id.alu;
      ID_mem_rd  = id.mrd;
      ID_mem_we  = id.mwe;
      ID_wd_sel  = id.wds;
      #2;
      lu        = model_load_use(m_ex, id);
      exp_stall = !rs && !fl && (lu || hd);
      check("stall_if_id", {63'd0, stall_if_id}, {63'd0, exp_stall});
      @(posedge clk);
      if (rs) begin
         m_ex = '0; m_stall = 0; m_flush = 0;
      end else if (fl) begin
         m_ex = '0;
         if (id.valid) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      end else if (hd) begin
         // everything frozen
      end else if (lu) begin
         m_ex = '0;
         m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      end else begin
         m_ex     = id;
         m_ex.use1 = 1'b0;
         m_ex.use2 = 1'b0;
         m_ex.we  = id.we  & id.valid;
         m_ex.mrd = id.mrd & id.valid;
         m_ex.mwe = id.mwe & id.valid;
      end
      #1;
      compare_outputs();
   endtask

   vec_t   vecs[15];
   instr_t lw5, dep5, nop;

   initial begin
      lw5  = mk(1'b1, 5'd5, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'd4);
      dep5 = mk(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 32'd0);
      nop  = '0;

      //        id                                                           fl    hd    stall valid wr     imm  scnt fcnt
      vecs[0]  = '{mk(1,5'd5,1,0,5'd0,1,5'd0,0,32'd7), 0,0, 0,1,5'd5,32'd7,0,0};  // addi x5
      vecs[1]  = '{lw5,                                0,0, 0,1,5'd5,32'd4,0,0};  // lw x5
      vecs[2]  = '{dep5,                               0,0, 1,0,5'd0,32'd0,1,0};  // add x6,x5 -> bubble
      vecs[3]  = '{dep5,                               0,0, 0,1,5'd6,32'd0,1,0};  // add issued
      vecs[4]  = '{mk(1,5'd0,1,1,5'd0,0,5'd0,0,32'd8), 0,0, 0,1,5'd0,32'd8,1,0};  // lw x0
      vecs[5]  = '{mk(1,5'd7,1,0,5'd0,1,5'd0,1,32'd1), 0,0, 0,1,5'd7,32'd1,1,0};  // reads x0
      vecs[6]  = '{lw5,                                0,0, 0,1,5'd5,32'd4,1,0};
      vecs[7]  = '{mk(1,5'd8,1,0,5'd1,1,5'd5,0,32'd2), 0,0, 0,1,5'd8,32'd2,1,0};  // rs2=5 unused
      vecs[8]  = '{lw5,                                0,0, 0,1,5'd5,32'd4,1,0};
      vecs[9]  = '{dep5,                               1,1, 0,0,5'd0,32'd0,1,1};  // flush beats lu+hold
      vecs[10] = '{mk(1,5'd9,1,0,5'd0,0,5'd0,0,32'd9), 0,0, 0,1,5'd9,32'd9,1,1};
      vecs[11] = '{mk(1,5'd3,1,0,5'd0,0,5'd0,0,32'd3), 0,1, 1,1,5'd9,32'd9,1,1};  // hold x3
      vecs[12] = '{mk(1,5'd3,1,0,5'd0,0,5'd0,0,32'd3), 0,1, 1,1,5'd9,32'd9,1,1};
      vecs[13] = '{mk(1,5'd3,1,0,5'd0,0,5'd0,0,32'd3), 0,1, 1,1,5'd9,32'd9,1,1};
      vecs[14] = '{mk(1,5'd3,1,0,5'd0,0,5'd0,0,32'd3), 0,0, 0,1,5'd3,32'd3,1,1};  // release

      m_ex = '0; m_stall = 0; m_flush = 0;
      rst = 1'b1;
      #1;

      // Reset held two cycles with random ID traffic and hold asserted.
      for (int i = 0; i < 2; i++) step(rand_instr(), 1'b0, 1'b1, 1'b1);
      check("reset EX_valid", {63'd0, EX_valid}, 64'd0);
      check("reset stall_cnt", {59'd0, stall_cnt}, 64'd0);

      for (int i = 0; i < 15; i++) begin
         step(vecs[i].id, vecs[i].flush, vecs[i].hold, 1'b0);
         check($sformatf("vec%0d stall_if_id", i), {63'd0, stall_if_id},
               {63'd0, (!vecs[i].flush && (vecs[i].hold || model_load_use(m_ex, nop)))});
         check($sformatf("vec%0d valid", i), {63'd0, EX_valid}, {63'd0, vecs[i].exp_valid});
         check($sformatf("vec%0d wr", i), {59'd0, EX_wr}, {59'd0, vecs[i].exp_wr});
         check($sformatf("vec%0d imm", i), {32'd0, EX_imm}, {32'd0, vecs[i].exp_imm});
         check($sformatf("vec%0d scnt", i), {59'd0, stall_cnt}, 64'(vecs[i].exp_scnt));
         check($sformatf("vec%0d fcnt", i), {59'd0, flush_cnt}, 64'(vecs[i].exp_fcnt));
      end

      // Reset in the middle of a load-use stall: next cycle must start clean.
      step(lw5, 1'b0, 1'b0, 1'b0);
      step(dep5, 1'b0, 1'b0, 1'b1);
      check("post-reset stall_cnt", {59'd0, stall_cnt}, 64'd0);
      step(dep5, 1'b0, 1'b0, 1'b0);
      check("post-reset issue wr", {59'd0, EX_wr}, 64'd6);

      // Saturation: 2^CNT_W + 2 load-use bubbles.
      for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
         step(lw5, 1'b0, 1'b0, 1'b0);
         step(dep5, 1'b0, 1'b0, 1'b0);
      end
      check("stall_cnt saturated", {59'd0, stall_cnt}, 64'(CNT_MAX));

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++)
         step(rand_instr(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 59) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
